mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. Takes registered EX/MEM fields and runs at most one data-memory transaction per instruction over a req/ack handshake, stalling upstream while it waits. Extracts and sign-extends bytes for `lb`, and selects the write-back value. Drives registered MEM/WB outputs to the register file and the forwarding unit.

---
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage unit: one req/ack data-memory transaction per instruction, lb byte
// extraction, write-back select, and registered MEM/WB outputs.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALUOut_MEM,
  input  logic [4:0]  Rw_MEM,
  input  logic [1:0]  MemtoReg_MEM,
  input  logic        RegWrite_MEM,
  input  logic [31:0] rt_MEM,
  input  logic        LoadByte_MEM,
  input  logic [31:0] PC_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        RegWrite_WB,
  output logic [4:0]  Rw_WB,
  output logic [31:0] WriteData_WB,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q;
  logic [CW-1:0]  wait_cnt_q;
  logic [1:0]     offs_q;

  logic           access;
  logic           abort;
  logic           done;
  logic [31:0]    rdata_eff;
  logic [7:0]     byte_sel;
  logic [31:0]    load_data;
  logic [31:0]    wb_data;

  assign access = MemRead_MEM | MemWrite_MEM;
  assign abort  = (state_q == BUSY) && !mem_ack && (wait_cnt_q == CW'(TIMEOUT - 1));
  assign done   = (state_q == BUSY) && (mem_ack || abort);
  assign stall  = !reset && (((state_q == IDLE) && access) || ((state_q == BUSY) && !done));

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    rdata_eff = mem_ack ? mem_rdata : 32'd0;
    byte_sel  = 8'd0;
    unique case (offs_q)
      2'd0: byte_sel = rdata_eff[7:0];
      2'd1: byte_sel = rdata_eff[15:8];
      2'd2: byte_sel = rdata_eff[23:16];
      2'd3: byte_sel = rdata_eff[31:24];
    endcase
    load_data = LoadByte_MEM ? {{24{byte_sel[7]}}, byte_sel} : rdata_eff;
    wb_data   = ALUOut_MEM;
    unique case (MemtoReg_MEM)
      2'd1:    wb_data = load_data;
      2'd2:    wb_data = PC_MEM + 32'd4;
      default: wb_data = ALUOut_MEM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      offs_q       <= 2'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      RegWrite_WB  <= 1'b0;
      Rw_WB        <= 5'd0;
      WriteData_WB <= 32'd0;
      bus_err      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            mem_req     <= 1'b1;
            mem_we      <= MemWrite_MEM;
            mem_addr    <= {ALUOut_MEM[31:2], 2'b00};
            mem_wdata   <= rt_MEM;
            offs_q      <= ALUOut_MEM[1:0];
            wait_cnt_q  <= '0;
            RegWrite_WB <= 1'b0;
            state_q     <= BUSY;
          end else begin
            RegWrite_WB  <= RegWrite_MEM;
            Rw_WB        <= Rw_MEM;
            WriteData_WB <= wb_data;
          end
        end
        BUSY: begin
          if (done) begin
            // EX/MEM fields are held by stall, so they still describe this access.
            RegWrite_WB  <= RegWrite_MEM;
            Rw_WB        <= Rw_MEM;
            WriteData_WB <= wb_data;
            mem_req      <= 1'b0;
            state_q      <= IDLE;
            if (abort) bus_err <= 1'b1;
          end else begin
            wait_cnt_q  <= wait_cnt_q + CW'(1);
            RegWrite_WB <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, lw/lb/sw, jal link,
// timeout abort and reset during an outstanding access.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, LoadByte_MEM;
  logic [31:0] ALUOut_MEM, rt_MEM, PC_MEM;
  logic [4:0]  Rw_MEM;
  logic [1:0]  MemtoReg_MEM;
  logic        mem_req, mem_we, mem_ack, stall, RegWrite_WB, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, WriteData_WB;
  logic [4:0]  Rw_WB;

  int n_vec = 0;
  int n_err = 0;

  int          stall_cnt, req_cnt, bubble_bad, unstable;
  logic        we_seen;
  logic [31:0] addr_seen, wdata_seen;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .ALUOut_MEM(ALUOut_MEM),
    .Rw_MEM(Rw_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .rt_MEM(rt_MEM), .LoadByte_MEM(LoadByte_MEM), .PC_MEM(PC_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .RegWrite_WB(RegWrite_WB), .Rw_WB(Rw_WB), .WriteData_WB(WriteData_WB),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    MemRead_MEM  = 1'b0; MemWrite_MEM = 1'b0; LoadByte_MEM = 1'b0;
    RegWrite_MEM = 1'b0; MemtoReg_MEM = 2'd0; Rw_MEM = 5'd0;
    ALUOut_MEM   = 32'd0; rt_MEM = 32'd0; PC_MEM = 32'd0;
    mem_ack      = 1'b0; mem_rdata = 32'd0;
  endtask

  // Non-memory instruction; returns at the negedge after its WB edge.
  task automatic alu_op(input logic [31:0] alu, input logic [31:0] pc, input logic [1:0] m2r,
                        input logic [4:0] rw, input logic rwen);
    @(posedge clk); #1;
    set_idle();
    ALUOut_MEM = alu; PC_MEM = pc; MemtoReg_MEM = m2r; Rw_MEM = rw; RegWrite_MEM = rwen;
    @(negedge clk);
    check("alu_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
  endtask

  // Memory instruction: cycle 0 is IDLE, cycles 1..nb are BUSY; ack driven in
  // cycle ack_at (0 = never). Returns at the negedge after the final edge.
  task automatic mem_op(input logic rd, input logic wr, input logic lb,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rdata,
                        input logic [1:0] m2r, input logic [4:0] rw, input logic rwen,
                        input int nb, input int ack_at);
    stall_cnt = 0; req_cnt = 0; bubble_bad = 0; unstable = 0;
    @(posedge clk); #1;
    set_idle();
    MemRead_MEM = rd; MemWrite_MEM = wr; LoadByte_MEM = lb; ALUOut_MEM = addr;
    rt_MEM = rt; MemtoReg_MEM = m2r; Rw_MEM = rw; RegWrite_MEM = rwen;
    for (int c = 0; c <= nb; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_ack   = (c == ack_at);
        mem_rdata = (c == ack_at) ? rdata : 32'hBAD0BAD0;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (c >= 1 && RegWrite_WB) bubble_bad++;
      if (c == 1) begin
        addr_seen = mem_addr; we_seen = mem_we; wdata_seen = mem_wdata;
      end else if (c > 1 && (mem_addr !== addr_seen || mem_we !== we_seen ||
                             mem_wdata !== wdata_seen || mem_req !== 1'b1)) begin
        unstable++;
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    MemRead_MEM = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    check("rst_wdata_wb", WriteData_WB, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    set_idle();

    // ALU op passes through in one cycle.
    alu_op(32'h0000_1234, 32'd0, 2'd0, 5'd5, 1'b1);
    check("alu_data", WriteData_WB, 32'h0000_1234);
    check("alu_rw", {27'd0, Rw_WB}, 32'd5);
    check("alu_regwrite", {31'd0, RegWrite_WB}, 32'd1);

    // lw 0x100, ack in BUSY cycle 3.
    mem_op(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, 2'd1, 5'd8, 1'b1, 3, 3);
    check("lw_stall_cycles", stall_cnt, 32'd3);
    check("lw_req_cycles", req_cnt, 32'd3);
    check("lw_addr", addr_seen, 32'h100);
    check("lw_we", {31'd0, we_seen}, 32'd0);
    check("lw_bubble", bubble_bad, 32'd0);
    check("lw_stable", unstable, 32'd0);
    check("lw_data", WriteData_WB, 32'hDEAD_BEEF);
    check("lw_rw", {27'd0, Rw_WB}, 32'd8);
    check("lw_regwrite", {31'd0, RegWrite_WB}, 32'd1);
    check("lw_req_done", {31'd0, mem_req}, 32'd0);

    // lb at each offset of 0x80112233.
    mem_op(1'b1, 1'b0, 1'b1, 32'h103, 32'd0, 32'h8011_2233, 2'd1, 5'd9, 1'b1, 1, 1);
    check("lb_103", WriteData_WB, 32'hFFFF_FF80);
    check("lb_addr", addr_seen, 32'h100);
    mem_op(1'b1, 1'b0, 1'b1, 32'h101, 32'd0, 32'h8011_2233, 2'd1, 5'd9, 1'b1, 1, 1);
    check("lb_101", WriteData_WB, 32'h0000_0022);
    mem_op(1'b1, 1'b0, 1'b1, 32'h102, 32'd0, 32'h8011_2233, 2'd1, 5'd9, 1'b1, 1, 1);
    check("lb_102", WriteData_WB, 32'h0000_0011);
    mem_op(1'b1, 1'b0, 1'b1, 32'h100, 32'd0, 32'h8011_22B3, 2'd1, 5'd9, 1'b1, 1, 1);
    check("lb_100_neg", WriteData_WB, 32'hFFFF_FFB3);

    // sw 0x207, immediate ack: 2 cycles total, stall only in the IDLE cycle.
    mem_op(1'b0, 1'b1, 1'b0, 32'h207, 32'hCAFE_F00D, 32'd0, 2'd0, 5'd3, 1'b0, 1, 1);
    check("sw_we", {31'd0, we_seen}, 32'd1);
    check("sw_addr", addr_seen, 32'h204);
    check("sw_wdata", wdata_seen, 32'hCAFE_F00D);
    check("sw_stall_cycles", stall_cnt, 32'd1);
    check("sw_regwrite", {31'd0, RegWrite_WB}, 32'd0);

    // Read and write together is a write.
    mem_op(1'b1, 1'b1, 1'b0, 32'h300, 32'h1111_2222, 32'd0, 2'd0, 5'd3, 1'b0, 1, 1);
    check("rw_both_we", {31'd0, we_seen}, 32'd1);

    // jal link wraps; MemtoReg=3 selects ALU result.
    alu_op(32'h5555_0000, 32'hFFFF_FFFC, 2'd2, 5'd31, 1'b1);
    check("jal_data", WriteData_WB, 32'h0000_0000);
    check("jal_rw", {27'd0, Rw_WB}, 32'd31);
    alu_op(32'h0000_ABCD, 32'h0000_1000, 2'd3, 5'd7, 1'b1);
    check("m2r3_data", WriteData_WB, 32'h0000_ABCD);

    // Timeout: no ack, abort on the TIMEOUT-th BUSY cycle.
    mem_op(1'b1, 1'b0, 1'b0, 32'h400, 32'd0, 32'd0, 2'd1, 5'd10, 1'b1, TIMEOUT, 0);
    check("to_stall_cycles", stall_cnt, TIMEOUT);
    check("to_req_cycles", req_cnt, TIMEOUT);
    check("to_data", WriteData_WB, 32'd0);
    check("to_regwrite", {31'd0, RegWrite_WB}, 32'd1);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_req_done", {31'd0, mem_req}, 32'd0);
    alu_op(32'h0000_0042, 32'd0, 2'd0, 5'd4, 1'b1);
    check("to_idle_alu", WriteData_WB, 32'h0000_0042);
    check("to_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of BUSY; a late ack must be ignored.
    @(posedge clk); #1;
    set_idle();
    MemRead_MEM = 1'b1; ALUOut_MEM = 32'h500; MemtoReg_MEM = 2'd1; Rw_MEM = 5'd12; RegWrite_MEM = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("mid_rst_stall2", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_data", WriteData_WB, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
